// File: rtl/ad7276_pkg.sv
// ad7276_pkg: shared state encoding, frame constants and frame packing for the AD7276 responder
package ad7276_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  localparam int AD7276_FRAME_BITS = 16;
  localparam int AD7276_DATA_BITS  = 12;
  localparam int AD7276_LEAD_ZEROS = 2;
  function automatic logic [AD7276_FRAME_BITS-1:0] frame_word(input logic [AD7276_DATA_BITS-1:0] d);
    return {{AD7276_LEAD_ZEROS{1'b0}}, d, {AD7276_LEAD_ZEROS{1'b0}}};
  endfunction
endpackage

// File: rtl/ad7276_edge_sync.sv
// ad7276_edge_sync: multi-flop synchronizer with registered rise/fall detection
module ad7276_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic fpga_clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync   <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pin_i};
      prev   <= sync[SYNC_STAGES-1];
      rise_o <= ~prev & sync[SYNC_STAGES-1];
      fall_o <= prev & ~sync[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/ad7276_emu.sv
// ad7276_emu: dual-channel AD7276 serial read responder; AD7276_EMU_CNT_EN adds frame/error counters
module ad7276_emu
  import ad7276_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = AD7276_FRAME_BITS
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic [AD7276_DATA_BITS-1:0] sample_0_i,
  input  logic [AD7276_DATA_BITS-1:0] sample_1_i,
  input  logic                        sample_valid_i,
  output logic                        sample_ready_o,
  input  logic                        cs_i,
  input  logic                        sclk_i,
  output logic                        sdata_0_o,
  output logic                        sdata_1_o,
  output logic                        sdata_oe_o,
  output logic                        frame_done_o,
  output logic                        frame_err_o,
`ifdef AD7276_EMU_CNT_EN
  output logic [15:0]                 frame_cnt_o,
  output logic [15:0]                 err_cnt_o,
`endif
  output logic                        underrun_o
);
  localparam int DW = AD7276_DATA_BITS;
  localparam int FW = FRAME_BITS;
  state_t          state, state_n;
  logic [DW-1:0]   pend0, pend1, last0, last1, pend0_n, pend1_n, last0_n, last1_n;
  logic [FW-1:0]   sh0, sh1, sh0_n, sh1_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic            full, full_n, done_n, err_n, und_n;
  logic            cs_rise, cs_fall, sclk_fall, sclk_rise_unused, hs;
  ad7276_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .pin_i(cs_i),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );
  ad7276_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .pin_i(sclk_i),
    .rise_o(sclk_rise_unused), .fall_o(sclk_fall)
  );
  assign sample_ready_o = ~full;
  assign hs             = sample_valid_i & ~full;
  assign sdata_0_o      = (state == SHIFT) & sh0[FW-1];
  assign sdata_1_o      = (state == SHIFT) & sh1[FW-1];
  assign sdata_oe_o     = state != IDLE;
  always_comb begin
    state_n   = state;
    pend0_n   = hs ? sample_0_i : pend0;
    pend1_n   = hs ? sample_1_i : pend1;
    full_n    = hs | full;
    last0_n   = last0;
    last1_n   = last1;
    sh0_n     = sh0;
    sh1_n     = sh1;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    err_n     = 1'b0;
    und_n     = 1'b0;
    if (state == IDLE && cs_fall) begin
      // a handshake in this same cycle only fills pending for the next frame
      state_n   = SHIFT;
      bit_cnt_n = '0;
      sh0_n     = frame_word(full ? pend0 : last0);
      sh1_n     = frame_word(full ? pend1 : last1);
      last0_n   = full ? pend0 : last0;
      last1_n   = full ? pend1 : last1;
      full_n    = hs;
      und_n     = ~full;
    end else if (state == SHIFT && cs_rise) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (state == SHIFT && sclk_fall) begin
      sh0_n     = {sh0[FW-2:0], 1'b0};
      sh1_n     = {sh1[FW-2:0], 1'b0};
      bit_cnt_n = bit_cnt + 4'd1;
      state_n   = (bit_cnt == 4'(FW-1)) ? TAIL : SHIFT;
    end else if (state == TAIL && cs_rise) begin
      state_n = IDLE;
      done_n  = 1'b1;
    end
  end
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      pend0        <= '0;
      pend1        <= '0;
      full         <= 1'b0;
      last0        <= '0;
      last1        <= '0;
      sh0          <= '0;
      sh1          <= '0;
      bit_cnt      <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state        <= state_n;
      pend0        <= pend0_n;
      pend1        <= pend1_n;
      full         <= full_n;
      last0        <= last0_n;
      last1        <= last1_n;
      sh0          <= sh0_n;
      sh1          <= sh1_n;
      bit_cnt      <= bit_cnt_n;
      frame_done_o <= done_n;
      frame_err_o  <= err_n;
      underrun_o   <= und_n;
    end
  end
`ifdef AD7276_EMU_CNT_EN
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      frame_cnt_o <= frame_cnt_o + 16'(frame_done_o);
      err_cnt_o   <= err_cnt_o + 16'(frame_err_o);
    end
  end
`endif
endmodule

// File: doc/ad7276_emu.md
# ad7276_emu

Synthesizable responder for the AD7276 serial read protocol: emulates a pair of ADC data outputs sharing one CS/SCLK, for hardware-in-the-loop and loopback testing of the ADC capture path. Samples the external CS and SCLK lines, which are asynchronous to the FPGA clock, and shifts out 16-bit frames in the format 2 leading zeros, 12 data bits MSB first, then 2 trailing zeros. Sample words come from upstream logic through a valid/ready handshake.

## Interface
- SYNC_STAGES, 2: synchronizer flops on cs_i and sclk_i; legal range is 2–4.
- FRAME_BITS, 16: SCLK falling edges per frame; fixed by the protocol and not overridden.
- fpga_clk_i  in  1  sole clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- sample_0_i  in  12  channel 0 sample word.
- sample_1_i  in  12  channel 1 sample word.
- sample_valid_i  in  1  sample pair valid.
- sample_ready_o  out  1  pending buffer empty; handshake when valid and ready are both high.
- cs_i  in  1  ADC chip select from the master, active-low, asynchronous.
- sclk_i  in  1  serial clock from the master, asynchronous, idles high.
- sdata_0_o / sdata_1_o  out  1  serial data per channel.
- sdata_oe_o  out  1  output enable for the tristate pad; high while a frame is active.
- frame_done_o  out  1  one-cycle pulse after a complete 16-bit frame.
- frame_err_o  out  1  one-cycle pulse when CS rises mid-frame.
- underrun_o  out  1  one-cycle pulse when a frame starts with the pending buffer empty.

## Operation
- Synchronize cs_i and sclk_i through SYNC_STAGES flops. Register once more, then detect edges: cs_fall, cs_rise, sclk_fall.
- Pending buffer: 24 bits plus a full flag. sample_ready_o = !full. A handshake loads the buffer and sets full.
- Last-word register: holds the most recent pair shifted out. Reset value is 0.
- FSM states:
  - IDLE to SHIFT on cs_fall.
    - If full: load the shift regs with {2'b00, pending, 2'b00} per channel, copy pending into last-word, clear full.
    - Else: reload last-word and pulse underrun_o.
    - Set bit_cnt = 0 and assert sdata_oe_o.
  - SHIFT on sclk_fall: shift left one bit and increment bit_cnt.
    - When bit_cnt reaches 15 on a sclk_fall, go to TAIL.
    - On cs_rise with bit_cnt < 15: pulse frame_err_o and go to IDLE.
  - TAIL: drive sdata 0. On cs_rise, pulse frame_done_o and go to IDLE.
- sdata_x_o = shift_reg_x[15] in SHIFT; 0 in IDLE and TAIL.
- sdata_oe_o is high in SHIFT and TAIL only.
- Simultaneous cs_fall and handshake in the same cycle (buffer empty):
  - The frame uses last-word and underrun_o pulses.
  - The handshake fills pending for the next frame.
- sclk_fall while in IDLE is ignored.
- Extra sclk_fall events in TAIL are ignored; output stays 0.
- cs_fall and cs_rise cannot coincide, because the synchronized CS is a single bit.

## Timing
- Reset values: sdata_x_o = 0, sdata_oe_o = 0, sample_ready_o = 1, all pulse outputs = 0, state = IDLE, pending empty, last-word = 0.
- Pin edge to detect: SYNC_STAGES+1 cycles. Outputs are registered, so a pin edge reaches sdata/oe SYNC_STAGES+2 cycles after the edge.
- Bit 15 is presented after cs_fall. Each later bit appears SYNC_STAGES+2 cycles after an SCLK falling edge.
- The master samples on the SCLK falling edge and sees the bit that is stable before the shift.
- Constraint: each SCLK phase must be at least SYNC_STAGES+2 fpga_clk_i cycles; CS-fall to first SCLK fall must be at least SYNC_STAGES+3 cycles.
- frame_done_o and frame_err_o assert the cycle after cs_rise is detected.
- sample_ready_o rises the cycle after the frame-start load.

## Configuration
- AD7276_EMU_CNT_EN
  - Defined: adds 16-bit outputs frame_cnt_o and err_cnt_o. They increment on frame_done_o and frame_err_o, wrap at 0xFFFF, and reset to 0.
  - Undefined: the ports and the counters are absent.

## Structure
- Package ad7276_pkg:
  - State enum: IDLE, SHIFT, TAIL.
  - Constants: AD7276_FRAME_BITS = 16, AD7276_DATA_BITS = 12, AD7276_LEAD_ZEROS = 2.
- Sub-module ad7276_edge_sync: SYNC_STAGES synchronizer plus edge detector. Instantiated twice, for CS and for SCLK.

## Test plan
- Load pair (0xABC, 0x123), then run a 16-clock frame at SCLK = fpga_clk/8.
  - Master samples 0x2AF0 on channel 0 and 0x048C on channel 1.
  - frame_done_o pulses once and sample_ready_o returns high.
- Run two frames with no new sample after the first.
  - The second frame repeats the first word.
  - underrun_o pulses once, at the second cs_fall.
- Raise CS after 7 SCLK falls.
  - frame_err_o pulses, sdata_oe_o drops, and the state returns to IDLE.
  - The next full frame carries correct data.
- Assert sample_valid_i in the exact cycle cs_fall is detected, with the buffer empty.
  - underrun_o pulses and the frame uses last-word.
  - The next frame carries the new pair.
- Assert reset_i mid-frame at bit 9.
  - All outputs return to their reset values the next cycle.
  - A new frame after release outputs zeros, with underrun_o = 1.
- With AD7276_EMU_CNT_EN defined, run 3 good frames and 1 aborted frame.
  - frame_cnt_o = 3, err_cnt_o = 1.
